// File: rtl/pipeline_divider.sv
// Multi-cycle restoring divider for the EX stage: DIV/DIVU/REM/REMU with
// pipeline stall generation, one-cycle done pulse and early-out special cases.
module pipeline_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall_out,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH:0]   rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] div_reg;
    logic             is_rem_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             done_reg;
    logic [WIDTH-1:0] result_reg;

    // Operand decode in IDLE: op[0]=0 selects the signed variants.
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] special_result;

    assign is_signed      = ~op[0];
    assign a_neg          = is_signed & a[WIDTH-1];
    assign b_neg          = is_signed & b[WIDTH-1];
    assign a_mag          = a_neg ? -a : a;
    assign b_mag          = b_neg ? -b : b;
    assign div_zero       = (b == '0);
    assign overflow       = is_signed && (a == MOST_NEG) && (b == '1);
    assign special_result = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

    // One restoring step: shift in next dividend bit, trial-subtract divisor.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    assign rem_shift = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, div_reg};
    assign q_final   = neg_q_reg ? -quo_reg : quo_reg;
    assign r_final   = neg_r_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];

    assign stall_out = ((state_reg == IDLE) && start && !flush) || (state_reg == BUSY);
    assign done      = done_reg;
    assign result    = result_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            div_reg    <= '0;
            is_rem_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
        end else if (flush) begin
            state_reg <= IDLE;
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        if (div_zero || overflow) begin
                            result_reg <= special_result;
                            done_reg   <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            rem_reg    <= '0;
                            quo_reg    <= a_mag;
                            div_reg    <= b_mag;
                            is_rem_reg <= op[1];
                            neg_q_reg  <= a_neg ^ b_neg;
                            neg_r_reg  <= a_neg;
                            count_reg  <= CW'(WIDTH);
                            state_reg  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // Final BUSY cycle applies the sign correction to the result.
                    if (count_reg == '0) begin
                        result_reg <= is_rem_reg ? r_final : q_final;
                        done_reg   <= 1'b1;
                        state_reg  <= DONE;
                    end else begin
                        if (!diff[WIDTH]) begin
                            rem_reg <= diff;
                        end else begin
                            rem_reg <= rem_shift;
                        end
                        quo_reg   <= {quo_reg[WIDTH-2:0], ~diff[WIDTH]};
                        count_reg <= count_reg - CW'(1);
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
